// File: rtl/updown_counter.sv
// updown_counter: modulo-N up/down counter with synchronous parallel load,
// wrap or saturate behaviour at the boundaries, a combinational terminal-count
// flag and a registered boundary-event (carry) flag.
module updown_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             carry
);

  // Highest legal count and the reset value, both held in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);

  // Modulus is compared one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MODULUS_WIDE = (WIDTH + 1)'(MODULUS);

  // Reject parameter sets that would let the count leave 0..MODULUS-1.
  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
      $error("updown_counter: RESET_VALUE %0d not below MODULUS", RESET_VALUE);
    end
  endgenerate

  logic [WIDTH-1:0] next_out;
  logic             next_carry;
  logic             at_top;
  logic             at_bottom;
  logic             load_in_range;

  assign at_top        = (out == MAX_COUNT);
  assign at_bottom     = (out == '0);
  assign load_in_range = ({1'b0, load_value} < MODULUS_WIDE);

  // Terminal count looks at the current count and the direction being requested.
  assign tc = enable & (up ? at_top : at_bottom);

  // Next count and carry: load beats enable, out-of-range loads clamp to the top.
  always_comb begin
    next_out   = out;
    next_carry = 1'b0;
    if (load) begin
      next_out = load_in_range ? load_value : MAX_COUNT;
    end else if (enable) begin
      if (up) begin
        if (at_top) begin
          next_carry = 1'b1;
          next_out   = SATURATE ? out : '0;
        end else begin
          next_out = out + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          next_carry = 1'b1;
          next_out   = SATURATE ? out : MAX_COUNT;
        end else begin
          next_out = out - WIDTH'(1);
        end
      end
    end
  end

  // Count and carry registers; a low reset overrides load and enable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out   <= RST_COUNT;
      carry <= 1'b0;
    end else begin
      out   <= next_out;
      carry <= next_carry;
    end
  end

endmodule
